// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore control FSM for a multicycle MIPS-style datapath.
//               Decodes lw, sw, R-type (add/sub/and/or/slt/jr), beq, addi
//               and j. Each output is registered alongside the state it
//               belongs to. Write strobes are masked while reset is high.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int ALUCTL_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                PCWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                memWrite,
  output logic                memToReg,
  output logic                regDst,
  output logic                regWriteEnable,
  output logic                branch,
  output logic                ALUSrcA,
  output logic                pcEn,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;
  localparam logic [5:0] c_fn_jr  = 6'b001000;

  localparam logic [ALUCTL_W-1:0] c_alu_and = ALUCTL_W'(5'b00000);
  localparam logic [ALUCTL_W-1:0] c_alu_or  = ALUCTL_W'(5'b00001);
  localparam logic [ALUCTL_W-1:0] c_alu_add = ALUCTL_W'(5'b00010);
  localparam logic [ALUCTL_W-1:0] c_alu_sub = ALUCTL_W'(5'b00110);
  localparam logic [ALUCTL_W-1:0] c_alu_slt = ALUCTL_W'(5'b00111);

  state_t              r_state;
  state_t              w_next;
  logic                r_pcwrite, r_iord, r_irwrite, r_memwrite, r_memtoreg;
  logic                r_regdst, r_regwe, r_branch, r_alusrca;
  logic [1:0]          r_alusrcb, r_pcsrc;
  logic [ALUCTL_W-1:0] r_aluctl;
  logic                w_pcwrite, w_iord, w_irwrite, w_memwrite, w_memtoreg;
  logic                w_regdst, w_regwe, w_branch, w_alusrca;
  logic [1:0]          w_alusrcb, w_pcsrc;
  logic [ALUCTL_W-1:0] w_aluctl;
  logic [ALUCTL_W-1:0] w_funct_alu;

  // Next-state selection; unused codes fall back to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          c_op_lw, c_op_sw: w_next = S_MEMADR;
          c_op_rtype: begin
            case (funct)
              c_fn_jr:                                     w_next = S_JR;
              c_fn_add, c_fn_sub, c_fn_and, c_fn_or, c_fn_slt: w_next = S_EXECUTE;
              default:                                     w_next = S_FETCH;
            endcase
          end
          c_op_beq:  w_next = S_BRANCH;
          c_op_addi: w_next = S_ADDIEX;
          c_op_j:    w_next = S_JUMP;
          default:   w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (opcode == c_op_lw) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // ALU operation for an R-type instruction, from its funct field.
  always_comb begin
    w_funct_alu = c_alu_add;
    case (funct)
      c_fn_sub: w_funct_alu = c_alu_sub;
      c_fn_and: w_funct_alu = c_alu_and;
      c_fn_or:  w_funct_alu = c_alu_or;
      c_fn_slt: w_funct_alu = c_alu_slt;
      default:  w_funct_alu = c_alu_add;
    endcase
  end

  // Moore outputs for the state being entered, so they register with it.
  always_comb begin
    w_pcwrite  = 1'b0;
    w_iord     = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_regdst   = 1'b0;
    w_regwe    = 1'b0;
    w_branch   = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluctl   = c_alu_add;
    case (w_next)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE:   w_alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMREAD:  w_iord = 1'b1;
      S_MEMWRITE: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwe    = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluctl  = w_funct_alu;
      end
      S_ALUWB: begin
        w_regdst = 1'b1;
        w_regwe  = 1'b1;
      end
      S_ADDIWB:   w_regwe = 1'b1;
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluctl  = c_alu_sub;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_JR: begin
        w_pcsrc   = 2'b11;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers; reset parks everything in FETCH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pcwrite  <= 1'b1;
      r_iord     <= 1'b0;
      r_irwrite  <= 1'b1;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regdst   <= 1'b0;
      r_regwe    <= 1'b0;
      r_branch   <= 1'b0;
      r_alusrca  <= 1'b0;
      r_alusrcb  <= 2'b01;
      r_pcsrc    <= 2'b00;
      r_aluctl   <= c_alu_add;
    end else begin
      r_state    <= w_next;
      r_pcwrite  <= w_pcwrite;
      r_iord     <= w_iord;
      r_irwrite  <= w_irwrite;
      r_memwrite <= w_memwrite;
      r_memtoreg <= w_memtoreg;
      r_regdst   <= w_regdst;
      r_regwe    <= w_regwe;
      r_branch   <= w_branch;
      r_alusrca  <= w_alusrca;
      r_alusrcb  <= w_alusrcb;
      r_pcsrc    <= w_pcsrc;
      r_aluctl   <= w_aluctl;
    end
  end

  // Write strobes are held off for the whole reset pulse; the FETCH reset
  // values take effect the moment reset releases, so the first edge fetches.
  assign PCWrite        = r_pcwrite  & ~reset;
  assign IRWrite        = r_irwrite  & ~reset;
  assign memWrite       = r_memwrite & ~reset;
  assign regWriteEnable = r_regwe    & ~reset;
  assign IorD           = r_iord;
  assign memToReg       = r_memtoreg;
  assign regDst         = r_regdst;
  assign branch         = r_branch;
  assign ALUSrcA        = r_alusrca;
  assign ALUSrcB        = r_alusrcb;
  assign PCSrc          = r_pcsrc;
  assign ALUControl     = r_aluctl;
  assign pcEn           = PCWrite | (r_branch & zero);
  assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed, table-driven self-checking bench for
//               multicycle_control, plus a hand-written reset-abort sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic [5:0] funct = 6'b0;
  logic       zero = 1'b0;
  logic       PCWrite, IorD, IRWrite, memWrite, memToReg, regDst;
  logic       regWriteEnable, branch, ALUSrcA, pcEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [4:0] ALUControl;
  logic [3:0] state;

  multicycle_control #(.ALUCTL_W(5)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .memWrite(memWrite),
    .memToReg(memToReg), .regDst(regDst), .regWriteEnable(regWriteEnable),
    .branch(branch), .ALUSrcA(ALUSrcA), .pcEn(pcEn), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .ALUControl(ALUControl), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pcwrite, iord, irwrite, memwrite, memtoreg;
    logic       regdst, regwe, br, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [4:0] aluctl;
  } out_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic [3:0] st;
    out_t       o;
  } vec_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] ILL = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_JR = 6'b001000;
  localparam logic [4:0] A_AND = 5'b00000, A_OR = 5'b00001, A_ADD = 5'b00010;
  localparam logic [4:0] A_SUB = 5'b00110, A_SLT = 5'b00111;

  out_t act;
  assign act = {PCWrite, IorD, IRWrite, memWrite, memToReg, regDst, regWriteEnable,
                branch, ALUSrcA, pcEn, ALUSrcB, PCSrc, ALUControl};

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   lwseq[5] = '{1, 2, 3, 4, 0};

  out_t E_FETCH_R, E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, E_MEMWR;
  out_t E_ALUWB, E_ADDIEX, E_ADDIWB, E_JUMP, E_JR;

  function automatic out_t mk(input logic pcw, iord, irw, memw, m2r, rdst, rwe,
                              input logic br, asa, pcen, input logic [1:0] asb,
                              input logic [1:0] pcs, input logic [4:0] alu);
    out_t o;
    o.pcwrite = pcw;  o.iord = iord;  o.irwrite = irw;  o.memwrite = memw;
    o.memtoreg = m2r; o.regdst = rdst; o.regwe = rwe;   o.br = br;
    o.alusrca = asa;  o.pcen = pcen;  o.alusrcb = asb;  o.pcsrc = pcs;
    o.aluctl = alu;
    return o;
  endfunction

  function automatic out_t e_exec(input logic [4:0] alu);
    return mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,alu);
  endfunction

  function automatic out_t e_br(input logic z);
    return mk(0,0,0,0,0,0,0,1,1,z,2'b00,2'b01,A_SUB);
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic [3:0] st, input out_t o);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.st = st; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [4:0] alu);
    add(0, RT, fn, 0, 4'd0, E_FETCH);
    add(0, RT, fn, 1, 4'd1, E_DECODE);
    add(0, RT, fn, 0, 4'd6, e_exec(alu));
    add(0, RT, fn, 1, 4'd7, E_ALUWB);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                 pcw iord irw memw m2r rdst rwe br asa pcen asb    pcs    alu
    E_FETCH_R = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, A_ADD);
    E_FETCH   = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, A_ADD);
    E_DECODE  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, A_ADD);
    E_MEMADR  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, A_ADD);
    E_MEMREAD = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, A_ADD);
    E_MEMWB   = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, A_ADD);
    E_MEMWR   = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, A_ADD);
    E_ALUWB   = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, A_ADD);
    E_ADDIEX  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, A_ADD);
    E_ADDIWB  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, A_ADD);
    E_JUMP    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, A_ADD);
    E_JR      = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b11, A_ADD);

    // reset held, then release: FETCH values with write strobes masked/unmasked
    add(1, LW, 0, 0, 4'd0, E_FETCH_R);
    add(1, LW, 0, 1, 4'd0, E_FETCH_R);
    // lw: 5 cycles
    add(0, LW, 0, 0, 4'd0, E_FETCH);
    add(0, LW, 0, 0, 4'd1, E_DECODE);
    add(0, LW, 0, 0, 4'd2, E_MEMADR);
    add(0, LW, 0, 0, 4'd3, E_MEMREAD);
    add(0, LW, 0, 1, 4'd4, E_MEMWB);
    // sw: 4 cycles
    add(0, SW, 0, 0, 4'd0, E_FETCH);
    add(0, SW, 0, 0, 4'd1, E_DECODE);
    add(0, SW, 0, 0, 4'd2, E_MEMADR);
    add(0, SW, 0, 0, 4'd5, E_MEMWR);
    // R-type: 4 cycles each
    rtype(F_SUB, A_SUB);
    rtype(F_ADD, A_ADD);
    rtype(F_AND, A_AND);
    rtype(F_OR,  A_OR);
    rtype(F_SLT, A_SLT);
    // addi: 4 cycles
    add(0, ADDI, 0, 0, 4'd0, E_FETCH);
    add(0, ADDI, 0, 0, 4'd1, E_DECODE);
    add(0, ADDI, 0, 0, 4'd9, E_ADDIEX);
    add(0, ADDI, 0, 0, 4'd10, E_ADDIWB);
    // beq taken / not taken: 3 cycles each
    add(0, BEQ, 0, 0, 4'd0, E_FETCH);
    add(0, BEQ, 0, 1, 4'd1, E_DECODE);
    add(0, BEQ, 0, 1, 4'd8, e_br(1'b1));
    add(0, BEQ, 0, 0, 4'd0, E_FETCH);
    add(0, BEQ, 0, 0, 4'd1, E_DECODE);
    add(0, BEQ, 0, 0, 4'd8, e_br(1'b0));
    // j and jr: 3 cycles each
    add(0, J, 0, 0, 4'd0, E_FETCH);
    add(0, J, 0, 0, 4'd1, E_DECODE);
    add(0, J, 0, 1, 4'd11, E_JUMP);
    add(0, RT, F_JR, 0, 4'd0, E_FETCH);
    add(0, RT, F_JR, 0, 4'd1, E_DECODE);
    add(0, RT, F_JR, 0, 4'd12, E_JR);
    // illegal opcode and illegal R-type funct: 2 cycles each
    add(0, ILL, 0, 1, 4'd0, E_FETCH);
    add(0, ILL, 0, 1, 4'd1, E_DECODE);
    add(0, RT, ILL, 0, 4'd0, E_FETCH);
    add(0, RT, ILL, 0, 4'd1, E_DECODE);
    add(0, SW, 0, 0, 4'd0, E_FETCH);

    foreach (vecs[i]) begin
      @(negedge clock);
      reset  = vecs[i].rst;
      opcode = vecs[i].op;
      funct  = vecs[i].fn;
      zero   = vecs[i].z;
      #1;
      check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d outputs", i), 32'(act), 32'(vecs[i].o));
      tests++;
      if ($countones({regWriteEnable, memWrite, IRWrite}) > 1) begin
        fails++;
        $display("FAIL vec%0d write-exclusive: got %b, expected at most one set",
                 i, {regWriteEnable, memWrite, IRWrite});
      end
    end

    // sw into MEMWRITE, then asynchronous reset between edges
    @(negedge clock); #1;
    check("abort decode state", 32'(state), 32'd1);
    @(negedge clock); #1;
    check("abort memadr state", 32'(state), 32'd2);
    @(negedge clock); #1;
    check("abort memwrite state", 32'(state), 32'd5);
    check("abort memWrite before reset", 32'(memWrite), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset state", 32'(state), 32'd0);
    check("async reset memWrite", 32'(memWrite), 32'd0);
    check("async reset IRWrite", 32'(IRWrite), 32'd0);
    check("async reset pcEn", 32'(pcEn), 32'd0);
    opcode = LW;
    @(negedge clock); #1;
    check("reset held state", 32'(state), 32'd0);
    check("reset held memWrite", 32'(memWrite), 32'd0);
    reset = 1'b0;
    #1;
    check("post-release state", 32'(state), 32'd0);
    check("post-release IRWrite", 32'(IRWrite), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); #1;
      check($sformatf("lw after reset step%0d state", k), 32'(state), 32'(lwseq[k]));
      check($sformatf("lw after reset step%0d regWE", k), 32'(regWriteEnable),
            32'(lwseq[k] == 4));
      check($sformatf("lw after reset step%0d memToReg", k), 32'(memToReg),
            32'(lwseq[k] == 4));
      check($sformatf("lw after reset step%0d memWrite", k), 32'(memWrite), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
